// File: rtl/button_evt_pkg.sv
// Shared types for the button gesture classifier: gesture FSM states and
// the event codes handed to the menu/vote control logic.
package button_evt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    GAP,
    PRESS2,
    HOLD
  } gesture_state_e;

  localparam logic [1:0] EVT_NONE   = 2'b00;
  localparam logic [1:0] EVT_SHORT  = 2'b01;
  localparam logic [1:0] EVT_LONG   = 2'b10;
  localparam logic [1:0] EVT_DOUBLE = 2'b11;

endpackage

// File: rtl/button_evt_slot.sv
// One-entry valid/ready holding register for classified button events.
// A new event arriving while the held one is stalled is dropped and flagged.
module button_evt_slot
  import button_evt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_in_valid,
  input  logic [1:0] i_in_code,
  input  logic       i_evt_ready,
  input  logic       i_ovf_clr,
  output logic       o_evt_valid,
  output logic [1:0] o_evt_code,
  output logic       o_ovf
);

  logic       r_valid;
  logic [1:0] r_code;
  logic       r_ovf;
  logic       w_drop;
  logic       w_load;

  assign w_drop = i_in_valid & r_valid & ~i_evt_ready;
  assign w_load = i_in_valid & ~w_drop;

  // A drop wins over a same-cycle clear so the loss is never hidden.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_code  <= EVT_NONE;
      r_ovf   <= 1'b0;
    end else begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_code  <= i_in_code;
      end else if (r_valid && i_evt_ready) begin
        r_valid <= 1'b0;
        r_code  <= EVT_NONE;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (i_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign o_evt_valid = r_valid;
  assign o_evt_code  = r_code;
  assign o_ovf       = r_ovf;

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced button gestures into SHORT, LONG or DOUBLE presses
// and hands them to the control FSM through a one-entry event slot.
module button_press_classifier
  import button_evt_pkg::*;
#(
  parameter int LONG_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 15_000_000,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_level,
  output logic       o_evt_valid,
  output logic [1:0] o_evt_code,
  input  logic       i_evt_ready,
  output logic       o_ovf,
  input  logic       i_ovf_clr
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  gesture_state_e   r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_prev;
  logic             w_rise;
  logic             w_fall;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_emit;
  logic [1:0]       w_emit_code;

  assign w_rise    = i_btn_level & ~r_prev;
  assign w_fall    = ~i_btn_level & r_prev;
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_ONE;

  // Events feed the slot combinationally so they register on the same edge
  // that ends the terminating sample.
  always_comb begin
    w_emit      = 1'b0;
    w_emit_code = EVT_NONE;
    unique case (r_state)
      PRESS1: if (i_btn_level && r_cnt == LONG_LAST) begin
        w_emit      = 1'b1;
        w_emit_code = EVT_LONG;
      end
      GAP: if (!i_btn_level && r_cnt == GAP_LAST) begin
        w_emit      = 1'b1;
        w_emit_code = EVT_SHORT;
      end
      PRESS2: if (w_fall) begin
        w_emit      = 1'b1;
        w_emit_code = EVT_DOUBLE;
      end
      default: ;
    endcase
  end

  // Entering PRESS1 or GAP loads 1 because the edge sample itself counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev  <= 1'b1;
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_prev <= i_btn_level;
      r_cnt  <= w_cnt_inc;
      unique case (r_state)
        IDLE: if (w_rise) begin
          r_state <= PRESS1;
          r_cnt   <= CNT_ONE;
        end
        PRESS1: if (i_btn_level && r_cnt == LONG_LAST) begin
          r_state <= HOLD;
          r_cnt   <= '0;
        end else if (w_fall) begin
          r_state <= GAP;
          r_cnt   <= CNT_ONE;
        end
        GAP: if (w_rise) begin
          r_state <= PRESS2;
          r_cnt   <= '0;
        end else if (!i_btn_level && r_cnt == GAP_LAST) begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
        PRESS2, HOLD: if (w_fall) begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  button_evt_slot u_slot (
    .clk         (clk),
    .rst         (rst),
    .i_in_valid  (w_emit),
    .i_in_code   (w_emit_code),
    .i_evt_ready (i_evt_ready),
    .i_ovf_clr   (i_ovf_clr),
    .o_evt_valid (o_evt_valid),
    .o_evt_code  (o_evt_code),
    .o_ovf       (o_ovf)
  );

endmodule
